// File: rtl/delay_bank_pkg.sv
// Shared helpers for the delay_line_bank: depth-field width and per-lane reset depth.
// DELAY_BANK_SKEW_INIT_EN selects the staircase reset depth (lane c -> c+1) instead of MAX_DEPTH.
package delay_bank_pkg;

`ifdef DELAY_BANK_SKEW_INIT_EN
  localparam bit SKEW_INIT = 1'b1;
`else
  localparam bit SKEW_INIT = 1'b0;
`endif

  function automatic int depth_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  function automatic int reset_depth(input int lane, input int max_depth);
    return (SKEW_INIT && (lane + 1 < max_depth)) ? lane + 1 : max_depth;
  endfunction

endpackage

// File: rtl/delay_lane.sv
// One lane of the delay bank: MAX_DEPTH-stage {valid, data} shift register,
// a programmable depth register and the output tap mux.
module delay_lane
  import delay_bank_pkg::*;
#(
  parameter int BITS      = 64,
  parameter int MAX_DEPTH = 8,
  parameter int RST_DEPTH = MAX_DEPTH,
  localparam int DW       = depth_w(MAX_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic            cfg_load,
  input  logic [DW-1:0]   cfg_depth,
  input  logic [BITS-1:0] d,
  input  logic            d_valid,
  output logic [BITS-1:0] q,
  output logic            q_valid
);

  typedef struct packed {
    logic            valid;
    logic [BITS-1:0] data;
  } stage_t;

  stage_t        stage [MAX_DEPTH];
  stage_t        tap;
  logic [DW-1:0] depth;

  // A depth load clears every valid bit of the lane except the one entering stage 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_DEPTH; k++) stage[k] <= '0;
      depth <= DW'(RST_DEPTH);
    end else if (flush) begin
      for (int k = 0; k < MAX_DEPTH; k++) stage[k] <= '0;
    end else begin
      if (cfg_load) depth <= cfg_depth;
      if (en) begin
        stage[0] <= {d_valid, d};
        for (int k = 1; k < MAX_DEPTH; k++) begin
          stage[k].data  <= stage[k-1].data;
          stage[k].valid <= stage[k-1].valid & ~cfg_load;
        end
      end else if (cfg_load) begin
        for (int k = 0; k < MAX_DEPTH; k++) stage[k].valid <= 1'b0;
      end
    end
  end

  always_comb begin
    tap = stage[0];
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (depth == DW'(k + 1)) tap = stage[k];
    end
  end

  assign q       = tap.data;
  assign q_valid = tap.valid;

endmodule

// File: rtl/delay_line_bank.sv
// Multi-lane programmable delay buffer: decodes and range-checks depth writes, flags rejects.
// Reset depths follow DELAY_BANK_SKEW_INIT_EN (staircase) when defined, else MAX_DEPTH.
module delay_line_bank
  import delay_bank_pkg::*;
#(
  parameter int CHANNELS  = 8,
  parameter int BITS      = 64,
  parameter int MAX_DEPTH = 8,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int DW       = depth_w(MAX_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CHANNELS*BITS-1:0] d,
  input  logic [CHANNELS-1:0]      d_valid,
  input  logic                     flush,
  input  logic                     cfg_we,
  input  logic [CW-1:0]            cfg_ch,
  input  logic [DW-1:0]            cfg_depth,
  output logic [CHANNELS*BITS-1:0] q,
  output logic [CHANNELS-1:0]      q_valid,
  output logic                     cfg_err
);

  logic cfg_ok;

  assign cfg_ok = cfg_we && (cfg_depth != '0) && (int'(cfg_depth) <= MAX_DEPTH)
                  && (int'(cfg_ch) < CHANNELS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we && !cfg_ok;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    delay_lane #(
      .BITS      (BITS),
      .MAX_DEPTH (MAX_DEPTH),
      .RST_DEPTH (reset_depth(c, MAX_DEPTH))
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .cfg_load  (cfg_ok && (int'(cfg_ch) == c)),
      .cfg_depth (cfg_depth),
      .d         (d[c*BITS +: BITS]),
      .d_valid   (d_valid[c]),
      .q         (q[c*BITS +: BITS]),
      .q_valid   (q_valid[c])
    );
  end

endmodule

// File: tb/tb_delay_line_bank.sv
// Directed testbench for delay_line_bank; expected reset depths track DELAY_BANK_SKEW_INIT_EN.
module tb_delay_line_bank;

  localparam int CHANNELS  = 8;
  localparam int BITS      = 64;
  localparam int MAX_DEPTH = 8;
  localparam int CW        = 3;
  localparam int DW        = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en;
  logic [CHANNELS*BITS-1:0] d;
  logic [CHANNELS-1:0]      d_valid;
  logic                     flush;
  logic                     cfg_we;
  logic [CW-1:0]            cfg_ch;
  logic [DW-1:0]            cfg_depth;
  logic [CHANNELS*BITS-1:0] q;
  logic [CHANNELS-1:0]      q_valid;
  logic                     cfg_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  delay_line_bank #(
    .CHANNELS  (CHANNELS),
    .BITS      (BITS),
    .MAX_DEPTH (MAX_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .d         (d),
    .d_valid   (d_valid),
    .flush     (flush),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_depth (cfg_depth),
    .q         (q),
    .q_valid   (q_valid),
    .cfg_err   (cfg_err)
  );

  function automatic int rst_depth(input int c);
`ifdef DELAY_BANK_SKEW_INIT_EN
    return (c + 1 < MAX_DEPTH) ? c + 1 : MAX_DEPTH;
`else
    return MAX_DEPTH;
`endif
  endfunction

  function automatic logic [BITS-1:0] lane_q(input int c);
    return q[c*BITS +: BITS];
  endfunction

  // lane c carries 100*c+n for sample n
  task automatic set_samples(input int n, input logic v);
    for (int c = 0; c < CHANNELS; c++) d[c*BITS +: BITS] = BITS'(100 * c + n);
    d_valid = {CHANNELS{v}};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (q !== '0) begin failures++; $display("FAIL reset_q got=%h exp=0", q); end
    checks++;
    if (q_valid !== '0) begin failures++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
    checks++;
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream;
    for (int k = 1; k <= 18; k++) begin
      en = 1'b1;
      set_samples(k - 1, k <= 10);
      tick();
      for (int c = 0; c < CHANNELS; c++) begin
        int  dc;
        logic ev;
        dc = rst_depth(c);
        ev = (k >= dc) && (k - dc <= 9);
        checks++;
        if (q_valid[c] !== ev) begin
          failures++;
          $display("FAIL stream_valid lane=%0d edge=%0d got=%b exp=%b", c, k, q_valid[c], ev);
        end
        if (ev) begin
          checks++;
          if (lane_q(c) !== BITS'(100 * c + k - dc)) begin
            failures++;
            $display("FAIL stream_data lane=%0d edge=%0d got=%0d exp=%0d", c, k, lane_q(c), 100 * c + k - dc);
          end
        end
      end
    end
    en = 1'b0;
    d_valid = '0;
  endtask

  task automatic test_en_toggle;
    do_flush();
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_depth = 4'd3;
    tick();
    cfg_we = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      en = (k % 2 == 1);
      set_samples(7, k == 1);
      tick();
      checks++;
      if (q_valid[0] !== (k >= 5)) begin
        failures++;
        $display("FAIL en_toggle_valid edge=%0d got=%b exp=%b", k, q_valid[0], k >= 5);
      end
      if (k >= 5) begin
        checks++;
        if (lane_q(0) !== BITS'(7)) begin
          failures++;
          $display("FAIL en_toggle_data edge=%0d got=%0d exp=7", k, lane_q(0));
        end
      end
    end
    en = 1'b0;
    d_valid = '0;
  endtask

  task automatic test_depth_write;
    int d5;
    int d6;
    do_flush();
    d6 = rst_depth(6);
    for (int k = 1; k <= 14; k++) begin
      en = 1'b1;
      set_samples(k - 1, 1'b1);
      cfg_we = (k == 10); cfg_ch = 3'd5; cfg_depth = 4'd2;
      tick();
      cfg_we = 1'b0;
      d5 = (k < 10) ? rst_depth(5) : 2;
      checks++;
      if (q_valid[5] !== ((k != 10) && (k >= d5))) begin
        failures++;
        $display("FAIL depth_write_valid5 edge=%0d got=%b exp=%b", k, q_valid[5], (k != 10) && (k >= d5));
      end
      if ((k != 10) && (k >= d5)) begin
        checks++;
        if (lane_q(5) !== BITS'(500 + k - d5)) begin
          failures++;
          $display("FAIL depth_write_data5 edge=%0d got=%0d exp=%0d", k, lane_q(5), 500 + k - d5);
        end
      end
      checks++;
      if (q_valid[6] !== (k >= d6)) begin
        failures++;
        $display("FAIL depth_write_valid6 edge=%0d got=%b exp=%b", k, q_valid[6], k >= d6);
      end
      if (k >= d6) begin
        checks++;
        if (lane_q(6) !== BITS'(600 + k - d6)) begin
          failures++;
          $display("FAIL depth_write_data6 edge=%0d got=%0d exp=%0d", k, lane_q(6), 600 + k - d6);
        end
      end
      checks++;
      if (q_valid[0] !== (k >= 3)) begin
        failures++;
        $display("FAIL depth_write_valid0 edge=%0d got=%b exp=%b", k, q_valid[0], k >= 3);
      end
    end
    en = 1'b0;
    d_valid = '0;
  endtask

  task automatic test_cfg_err;
    int d6;
    do_flush();
    d6 = rst_depth(6);
    for (int k = 1; k <= 12; k++) begin
      en = 1'b1;
      set_samples(k - 1, 1'b1);
      cfg_we = (k == 9) || (k == 11);
      cfg_ch = 3'd6;
      cfg_depth = (k == 9) ? 4'd0 : 4'd9;
      tick();
      cfg_we = 1'b0;
      checks++;
      if (cfg_err !== ((k == 9) || (k == 11))) begin
        failures++;
        $display("FAIL cfg_err edge=%0d got=%b exp=%b", k, cfg_err, (k == 9) || (k == 11));
      end
      checks++;
      if (q_valid[6] !== (k >= d6)) begin
        failures++;
        $display("FAIL cfg_err_valid6 edge=%0d got=%b exp=%b", k, q_valid[6], k >= d6);
      end
      if (k >= d6) begin
        checks++;
        if (lane_q(6) !== BITS'(600 + k - d6)) begin
          failures++;
          $display("FAIL cfg_err_data6 edge=%0d got=%0d exp=%0d", k, lane_q(6), 600 + k - d6);
        end
      end
    end
    en = 1'b0;
    d_valid = '0;
  endtask

  task automatic test_flush;
    do_flush();
    for (int k = 1; k <= 13; k++) begin
      en = 1'b1;
      set_samples(k - 1, 1'b1);
      flush = (k == 10);
      tick();
      flush = 1'b0;
      if (k == 10) begin
        checks++;
        if (q_valid !== '0) begin failures++; $display("FAIL flush_valid got=%b exp=0", q_valid); end
        checks++;
        if (q !== '0) begin failures++; $display("FAIL flush_data got=%h exp=0", q); end
      end else if (k > 10) begin
        checks++;
        if (q_valid[5] !== (k >= 12)) begin
          failures++;
          $display("FAIL flush_valid5 edge=%0d got=%b exp=%b", k, q_valid[5], k >= 12);
        end
        if (k >= 12) begin
          checks++;
          if (lane_q(5) !== BITS'(500 + k - 2)) begin
            failures++;
            $display("FAIL flush_data5 edge=%0d got=%0d exp=%0d", k, lane_q(5), 500 + k - 2);
          end
        end
        checks++;
        if (q_valid[0] !== (k >= 13)) begin
          failures++;
          $display("FAIL flush_valid0 edge=%0d got=%b exp=%b", k, q_valid[0], k >= 13);
        end
      end
    end
    en = 1'b0;
    d_valid = '0;
  endtask

  task automatic test_async_reset;
    do_flush();
    for (int k = 1; k <= 5; k++) begin
      en = 1'b1;
      set_samples(k - 1, 1'b1);
      tick();
    end
    checks++;
    if (q_valid[5] !== 1'b1) begin failures++; $display("FAIL pre_reset_valid5 got=%b exp=1", q_valid[5]); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (q !== '0) begin failures++; $display("FAIL async_reset_q got=%h exp=0", q); end
    checks++;
    if (q_valid !== '0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", q_valid); end
    #2 rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      set_samples(20 + k - 1, 1'b1);
      tick();
      for (int c = 0; c < CHANNELS; c += 5) begin
        int dc;
        dc = rst_depth(c);
        checks++;
        if (q_valid[c] !== (k >= dc)) begin
          failures++;
          $display("FAIL post_reset_valid lane=%0d edge=%0d got=%b exp=%b", c, k, q_valid[c], k >= dc);
        end
        if (k >= dc) begin
          checks++;
          if (lane_q(c) !== BITS'(100 * c + 20 + k - dc)) begin
            failures++;
            $display("FAIL post_reset_data lane=%0d edge=%0d got=%0d exp=%0d", c, k, lane_q(c), 100 * c + 20 + k - dc);
          end
        end
      end
    end
    en = 1'b0;
    d_valid = '0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_depth = '0; d = '0; d_valid = '0;
    test_reset();
    test_stream();
    test_en_toggle();
    test_depth_write();
    test_cfg_err();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
